// File: rtl/pll_lock_det_pkg.sv
// Shared definitions for the PLL lock detector: FSM state encoding and
// default measurement parameters.
package pll_lock_det_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ARM     = 2'd1,
        ST_ACQUIRE = 2'd2,
        ST_LOCKED  = 2'd3
    } state_e;

    localparam int DEF_MULT     = 8;
    localparam int DEF_TOL      = 1;
    localparam int DEF_LOCK_CNT = 4;
    localparam int DEF_CNT_W    = 8;

endpackage

// File: rtl/pll_lock_det_ref_sync_edge.sv
// Two-flop synchronizer for an asynchronous input followed by a third flop
// that turns each synchronized rising edge into a single-cycle pulse.
module ref_sync_edge (
    input  logic clk_i,
    input  logic rst_i,
    input  logic async_i,
    output logic edge_o
);

    logic sync1_q;
    logic sync2_q;
    logic dly_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            dly_q   <= 1'b0;
        end else begin
            sync1_q <= async_i;
            sync2_q <= sync1_q;
            dly_q   <= sync2_q;
        end
    end

    assign edge_o = sync2_q & ~dly_q;

endmodule

// File: rtl/pll_lock_det.sv
// Lock detector running on the PLL output clock: counts CLK cycles per REF
// period and declares lock after LOCK_CNT consecutive in-tolerance periods.
module pll_lock_det
    import pll_lock_det_pkg::*;
#(
    parameter int MULT     = DEF_MULT,
    parameter int TOL      = DEF_TOL,
    parameter int LOCK_CNT = DEF_LOCK_CNT,
    parameter int CNT_W    = DEF_CNT_W
) (
    input  logic             CLK,
    input  logic             reset,
    input  logic             REF,
    input  logic             ENb_VCO,
    output logic             LOCK,
    output logic [CNT_W-1:0] PERIOD,
    output logic             PERIOD_VALID,
    output logic             LOSS
);

    localparam int MC_W = (LOCK_CNT > 1) ? $clog2(LOCK_CNT + 1) : 1;
    localparam logic [CNT_W-1:0] SAT = {CNT_W{1'b1}};
    localparam int LO_INT = (MULT > TOL) ? (MULT - TOL) : 0;
    localparam int HI_INT = MULT + TOL;
    localparam logic [CNT_W:0] LO_B = (CNT_W+1)'(LO_INT);
    localparam logic [CNT_W:0] HI_B = (CNT_W+1)'(HI_INT);
    localparam logic [MC_W-1:0] MC_LAST = MC_W'(LOCK_CNT - 1);

    // Widened compare so MULT+TOL near the counter limit cannot wrap.
    function automatic logic in_window(input logic [CNT_W-1:0] p);
        logic [CNT_W:0] pw;
        pw = {1'b0, p};
        return (pw >= LO_B) && (pw <= HI_B) && (p != SAT);
    endfunction

    state_e            state_q;
    logic [CNT_W-1:0]  cnt_q;
    logic [CNT_W-1:0]  cnt_d;
    logic [MC_W-1:0]   mc_q;
    logic [CNT_W-1:0]  period_q;
    logic              pv_q;
    logic              lock_q;
    logic              loss_q;

    logic ref_edge;
    logic match;
    logic miss;
    logic sat_hit;

    ref_sync_edge u_ref_sync (
        .clk_i   (CLK),
        .rst_i   (reset),
        .async_i (REF),
        .edge_o  (ref_edge)
    );

    assign cnt_d   = (cnt_q == SAT) ? SAT : cnt_q + 1'b1;
    assign match   = pv_q && in_window(period_q);
    assign miss    = pv_q && !match;
    // Fires once, on the cycle the counter steps onto SAT without a REF edge.
    assign sat_hit = !ref_edge && (cnt_q == SAT - 1'b1);

    always_ff @(posedge CLK) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            mc_q     <= '0;
            period_q <= '0;
            pv_q     <= 1'b0;
            lock_q   <= 1'b0;
            loss_q   <= 1'b0;
        end else begin
            pv_q   <= 1'b0;
            loss_q <= 1'b0;
            if (ENb_VCO) begin
                state_q <= ST_IDLE;
                cnt_q   <= '0;
                mc_q    <= '0;
                lock_q  <= 1'b0;
            end else begin
                case (state_q)
                    ST_IDLE: state_q <= ST_ARM;
                    ST_ARM: begin
                        if (ref_edge) begin
                            state_q <= ST_ACQUIRE;
                            cnt_q   <= CNT_W'(1);
                            mc_q    <= '0;
                        end
                    end
                    ST_ACQUIRE, ST_LOCKED: begin
                        if (ref_edge) begin
                            period_q <= cnt_q;
                            pv_q     <= 1'b1;
                            cnt_q    <= CNT_W'(1);
                        end else begin
                            cnt_q <= cnt_d;
                        end
                        if (state_q == ST_ACQUIRE) begin
                            if (match) begin
                                if (mc_q == MC_LAST) begin
                                    state_q <= ST_LOCKED;
                                    lock_q  <= 1'b1;
                                    mc_q    <= '0;
                                end else begin
                                    mc_q <= mc_q + 1'b1;
                                end
                            end else if (miss || sat_hit) begin
                                mc_q <= '0;
                            end
                        end else if (miss || sat_hit) begin
                            state_q <= ST_ACQUIRE;
                            lock_q  <= 1'b0;
                            loss_q  <= 1'b1;
                            mc_q    <= '0;
                        end
                    end
                    default: state_q <= ST_IDLE;
                endcase
            end
        end
    end

    assign LOCK         = lock_q;
    assign PERIOD       = period_q;
    assign PERIOD_VALID = pv_q;
    assign LOSS         = loss_q;

endmodule

// File: tb/tb_pll_lock_det.sv
// Self-checking bench for pll_lock_det: a scoreboard of expected PERIOD
// values per REF edge, a table of REF-period phases, and corner sequences.
module tb_pll_lock_det;

    logic       CLK = 1'b0;
    logic       reset = 1'b1;
    logic       REF = 1'b0;
    logic       ENb_VCO = 1'b1;
    logic       LOCK;
    logic [7:0] PERIOD;
    logic       PERIOD_VALID;
    logic       LOSS;

    pll_lock_det dut (
        .CLK          (CLK),
        .reset        (reset),
        .REF          (REF),
        .ENb_VCO      (ENb_VCO),
        .LOCK         (LOCK),
        .PERIOD       (PERIOD),
        .PERIOD_VALID (PERIOD_VALID),
        .LOSS         (LOSS)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        int period;
        int nper;
        int stall;
        int exp_lock;
        int exp_loss;
        int exp_rises;
    } row_t;

    row_t rows[13];
    int   exp_q[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    int   last_rise = 0;
    bit   skip_next = 1'b1;
    int   loss_cnt = 0;
    int   rise_cnt = 0;
    logic prev_lock = 1'b0;
    int   e_mon;

    always @(posedge CLK) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge CLK);
            #1;
        end
    endtask

    task automatic rise();
        int iv;
        REF = 1'b1;
        iv = cyc - last_rise;
        if (skip_next || ENb_VCO) skip_next = 1'b0;
        else exp_q.push_back(iv > 255 ? 255 : iv);
        if (ENb_VCO) skip_next = 1'b1;
        last_rise = cyc;
    endtask

    task automatic ref_period(input int p);
        rise();
        tick(p / 2);
        REF = 1'b0;
        tick(p - p / 2);
    endtask

    // Scoreboard pop, LOSS accounting and LOCK-edge counting.
    always @(negedge CLK) begin
        if (!reset) begin
            if (PERIOD_VALID) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL pv_unexpected actual PERIOD=%0d required no PERIOD_VALID", PERIOD);
                end else begin
                    e_mon = exp_q.pop_front();
                    chk("period", 32'(PERIOD), e_mon);
                end
            end
            if (LOSS) begin
                loss_cnt++;
                chk("lock_low_on_loss", 32'(LOCK), 0);
                chk("lock_high_before_loss", 32'(prev_lock), 1);
            end
            if (LOCK && !prev_lock) rise_cnt++;
        end
        prev_lock = LOCK;
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int l0;
        int k0;
        int got;

        rows[0]  = '{8,  6,  0,   1, 0, 0};
        rows[1]  = '{12, 3,  0,   0, 1, 0};
        rows[2]  = '{8,  4,  0,   0, 0, 0};
        rows[3]  = '{8,  1,  0,   1, 0, 1};
        rows[4]  = '{10, 2,  0,   0, 1, 0};
        rows[5]  = '{9,  5,  0,   1, 0, 1};
        rows[6]  = '{10, 50, 0,   0, 1, 0};
        rows[7]  = '{7,  4,  0,   0, 0, 0};
        rows[8]  = '{7,  1,  0,   1, 0, 1};
        rows[9]  = '{6,  2,  0,   0, 1, 0};
        rows[10] = '{8,  5,  0,   1, 0, 1};
        rows[11] = '{8,  1,  300, 0, 1, 0};
        rows[12] = '{8,  5,  0,   1, 0, 1};

        tick(3);
        chk("rst_lock", 32'(LOCK), 0);
        chk("rst_period", 32'(PERIOD), 0);
        chk("rst_pv", 32'(PERIOD_VALID), 0);
        chk("rst_loss", 32'(LOSS), 0);
        reset = 1'b0;
        ENb_VCO = 1'b0;
        skip_next = 1'b1;
        tick(3);

        // Steady lock: arm + 3 matches, then the 4th match sets LOCK one cycle later.
        repeat (4) ref_period(8);
        chk("steady_lock_early", 32'(LOCK), 0);
        rise();
        got = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge CLK);
            if (got == 1) begin
                chk("steady_lock_rise", 32'(LOCK), 1);
                got = 2;
            end
            if (PERIOD_VALID && got == 0) begin
                chk("steady_lock_at_pv", 32'(LOCK), 0);
                got = 1;
            end
            @(posedge CLK);
            #1;
            if (i == 3) REF = 1'b0;
        end
        chk("steady_pv_seen", got, 2);

        for (int r = 0; r < 13; r++) begin
            l0 = loss_cnt;
            k0 = rise_cnt;
            repeat (rows[r].nper) ref_period(rows[r].period);
            tick(rows[r].stall);
            chk($sformatf("row%0d_lock", r), 32'(LOCK), rows[r].exp_lock);
            chk($sformatf("row%0d_loss", r), loss_cnt - l0, rows[r].exp_loss);
            chk($sformatf("row%0d_lockrise", r), rise_cnt - k0, rows[r].exp_rises);
        end

        // VCO disable while locked: LOCK drops without LOSS, PERIOD retained, edges ignored.
        l0 = loss_cnt;
        ENb_VCO = 1'b1;
        tick(1);
        chk("enb_lock", 32'(LOCK), 0);
        chk("enb_period_hold", 32'(PERIOD), 8);
        repeat (3) ref_period(8);
        chk("enb_no_loss", loss_cnt - l0, 0);
        chk("enb_period_hold2", 32'(PERIOD), 8);
        ENb_VCO = 1'b0;
        skip_next = 1'b1;
        tick(2);
        k0 = rise_cnt;
        repeat (4) ref_period(8);
        chk("reen_lock_early", 32'(LOCK), 0);
        ref_period(8);
        chk("reen_relock", 32'(LOCK), 1);
        chk("reen_lockrise", rise_cnt - k0, 1);

        // Reset in ACQUIRE with three matches banked.
        reset = 1'b1;
        tick(2);
        reset = 1'b0;
        skip_next = 1'b1;
        tick(2);
        repeat (4) ref_period(8);
        chk("pre_rst_lock", 32'(LOCK), 0);
        reset = 1'b1;
        tick(1);
        chk("midrst_lock", 32'(LOCK), 0);
        chk("midrst_period", 32'(PERIOD), 0);
        chk("midrst_pv", 32'(PERIOD_VALID), 0);
        chk("midrst_loss", 32'(LOSS), 0);
        tick(2);
        reset = 1'b0;
        skip_next = 1'b1;
        tick(2);
        repeat (4) ref_period(8);
        chk("postrst_lock_early", 32'(LOCK), 0);
        ref_period(8);
        chk("postrst_relock", 32'(LOCK), 1);

        tick(4);
        chk("queue_empty", exp_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
